multicycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle variant of the RV32 core; it replaces the single-cycle combinational control unit.
- Steps the shared ALU, register file and unified instruction/data memory through FETCH, DECODE, EXECUTE, MEM and WRITEBACK phases.
- Handshakes with memory via mem_ready, with a stall timeout.
- Supports R-type (ADD, SUB, AND, OR, SLT), LW, SW and BEQ. Any other instruction is trapped.

---
 rtl/multicycle_controller_if.sv | 42 ++++
 rtl/multicycle_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the RV32 datapath.
// Carries IR fields, ALU zero and memory ready into the controller, and datapath strobes out.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    // IR fields and datapath status
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    // Datapath strobes and selects
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    // Status
    logic       illegal_instr;
    logic       mem_error;
    logic       retire;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_instr, mem_error, retire, state_o
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_instr, mem_error, retire, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WB over a shared ALU and unified memory.
// Latency (zero-wait memory, FETCH entry to retire): R-type 4, LW 5, SW 4, BEQ 3 cycles.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready; MEM_TIMEOUT unanswered cycles trap.
//
// Ports: clk, rst_n (async active-low), bus (multicycle_controller_if.master):
//   in : opcode, funct3, funct7_5, zero, mem_ready
//   out: pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg,
//        alu_src_a, alu_src_b, alu_op, illegal_instr, mem_error, retire, state_o
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WR   = 4'd5,
        WB_R     = 4'd6,
        WB_MEM   = 4'd7,
        BRANCH   = 4'd8,
        TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // The counter holds the number of wait cycles already spent; the cycle in which
    // it would reach MEM_TIMEOUT is the last one mem_ready may still rescue.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;

    logic in_wait_state;
    logic timeout;
    logic r_legal;

    assign in_wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout       = in_wait_state && !bus.mem_ready && (wait_q == WAIT_LAST);

    // SUB (funct7_5=1) is only defined for funct3=000; AND/OR/SLT need funct7_5=0.
    assign r_legal = (bus.funct3 == 3'b000) ||
                     (!bus.funct7_5 && ((bus.funct3 == 3'b111) ||
                                        (bus.funct3 == 3'b110) ||
                                        (bus.funct3 == 3'b010)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next state and sticky flags
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d   = TRAP;
                    mem_err_d = 1'b1;
                end
            end
            DECODE: begin
                if (bus.opcode == OP_R && r_legal) begin
                    state_d = EXEC_R;
                end else if ((bus.opcode == OP_LOAD || bus.opcode == OP_STORE) &&
                             bus.funct3 == 3'b010) begin
                    state_d = MEM_ADDR;
                end else if (bus.opcode == OP_BR && bus.funct3 == 3'b000) begin
                    state_d = BRANCH;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC_R:   state_d = WB_R;
            WB_R:     state_d = FETCH;
            MEM_ADDR: state_d = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = WB_MEM;
                end else if (timeout) begin
                    state_d   = TRAP;
                    mem_err_d = 1'b1;
                end
            end
            MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d   = TRAP;
                    mem_err_d = 1'b1;
                end
            end
            WB_MEM:   state_d = FETCH;
            BRANCH:   state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
    end

    // Counting only while staying in the same wait state also clears it on entry
    // to any wait state and on any cycle mem_ready completes the access.
    always_comb begin
        wait_d = 8'd0;
        if (in_wait_state && !bus.mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    logic       pc_write, pc_src, ir_write, mem_read, mem_write, iord;
    logic       reg_write, mem_to_reg, retire;
    logic [1:0] alu_src_a, alu_src_b;
    logic [2:0] alu_op;

    // Moore decode of the current state, with mem_ready/zero-qualified strobes
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                case (bus.funct3)
                    3'b000:  alu_op = bus.funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = bus.mem_ready;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                pc_write  = bus.zero;
                pc_src    = bus.zero;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every output low even though FETCH would otherwise request memory.
    assign bus.pc_write      = rst_n & pc_write;
    assign bus.pc_src        = rst_n & pc_src;
    assign bus.ir_write      = rst_n & ir_write;
    assign bus.mem_read      = rst_n & mem_read;
    assign bus.mem_write     = rst_n & mem_write;
    assign bus.iord          = rst_n & iord;
    assign bus.reg_write     = rst_n & reg_write;
    assign bus.mem_to_reg    = rst_n & mem_to_reg;
    assign bus.retire        = rst_n & retire;
    assign bus.alu_src_a     = rst_n ? alu_src_a : 2'b00;
    assign bus.alu_src_b     = rst_n ? alu_src_b : 2'b00;
    assign bus.alu_op        = rst_n ? alu_op    : 3'b000;
    assign bus.illegal_instr = rst_n & illegal_q;
    assign bus.mem_error     = rst_n & mem_err_q;
    assign bus.state_o       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int T = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_MEM_ADDR = 3, S_MEM_RD = 4;
    localparam int S_MEM_WR = 5, S_WB_R = 6, S_WB_MEM = 7, S_BRANCH = 8, S_TRAP = 9;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int   st;
        logic rdy;
        logic ill;
        logic merr;
    } step_t;

    step_t seq[$];

    task automatic push(input int st, input logic rdy, input logic ill, input logic merr);
        step_t s;
        s.st = st; s.rdy = rdy; s.ill = ill; s.merr = merr;
        seq.push_back(s);
    endtask

    // A memory phase with w refusals: either it completes after w idle cycles,
    // or it runs out of patience after T idle cycles.
    task automatic push_wait(input int st, input int w, output bit ok);
        if (w >= T) begin
            for (int i = 0; i < T; i++) push(st, 1'b0, 1'b0, 1'b0);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0, 1'b0);
            push(st, 1'b1, 1'b0, 1'b0);
            ok = 1'b1;
        end
    endtask

    // {pc_write,pc_src,ir_write,mem_read,mem_write,iord,reg_write,mem_to_reg,a,b,alu_op,retire}
    function automatic logic [15:0] exp_outs(input int st, input logic rdy, input logic zf,
                                             input logic [2:0] f3, input logic f7);
        logic pw = 0, ps = 0, irw = 0, mr = 0, mw = 0, io = 0, rw = 0, m2r = 0, ret = 0;
        logic [1:0] a = 2'b00, b = 2'b00;
        logic [2:0] op = 3'b000;
        case (st)
            S_FETCH:    begin mr = 1; if (rdy) begin irw = 1; pw = 1; b = 2'b01; end end
            S_DECODE:   begin a = 2'b01; b = 2'b10; end
            S_EXEC_R:   begin
                a = 2'b10;
                if (f3 == 3'b000)      op = f7 ? 3'b001 : 3'b000;
                else if (f3 == 3'b111) op = 3'b010;
                else if (f3 == 3'b110) op = 3'b011;
                else                   op = 3'b100;
            end
            S_WB_R:     begin rw = 1; ret = 1; end
            S_MEM_ADDR: begin a = 2'b10; b = 2'b10; end
            S_MEM_RD:   begin mr = 1; io = 1; end
            S_MEM_WR:   begin mw = 1; io = 1; ret = rdy; end
            S_WB_MEM:   begin rw = 1; m2r = 1; ret = 1; end
            S_BRANCH:   begin a = 2'b10; op = 3'b001; pw = zf; ps = zf; ret = 1; end
            default: ;
        endcase
        return {pw, ps, irw, mr, mw, io, rw, m2r, a, b, op, ret};
    endfunction

    function automatic logic [15:0] got_outs();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
                bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.retire};
    endfunction

    // Holds reset for two cycles with busy-looking inputs; leaves rst_n low so the
    // next instruction releases it at a falling edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;
        bus.opcode    = OP_R;
        bus.funct3    = 3'b000;
        bus.funct7_5  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            check({name, ":rst_state"}, 32'(bus.state_o), 32'd0);
            check({name, ":rst_outs"}, 32'(got_outs()), 32'd0);
            check({name, ":rst_flags"}, 32'({bus.illegal_instr, bus.mem_error}), 32'd0);
            if (k == 0) @(negedge clk);
        end
    endtask

    task automatic play(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic zf, input int w_f, input int w_m,
                        input int hold, input int abort_at);
        bit ok;
        int cause;
        seq.delete();
        cause = 0;
        push_wait(S_FETCH, w_f, ok);
        if (!ok) begin
            cause = 2;
        end else begin
            push(S_DECODE, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (op == OP_R && (f3 == 3'b000 ||
                               (!f7 && (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010)))) begin
                push(S_EXEC_R, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                push(S_WB_R, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else if (op == OP_LW && f3 == 3'b010) begin
                push(S_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                push_wait(S_MEM_RD, w_m, ok);
                if (ok) push(S_WB_MEM, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                else    cause = 2;
            end else if (op == OP_SW && f3 == 3'b010) begin
                push(S_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                push_wait(S_MEM_WR, w_m, ok);
                if (!ok) cause = 2;
            end else if (op == OP_BEQ && f3 == 3'b000) begin
                push(S_BRANCH, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else begin
                cause = 1;
            end
        end
        if (cause != 0) begin
            for (int i = 0; i < hold; i++)
                push(S_TRAP, 1'($urandom_range(0, 1)), cause == 1, cause == 2);
        end

        foreach (seq[i]) begin
            if (i == abort_at) begin
                do_reset({name, ":abort"});
                return;
            end
            @(negedge clk);
            rst_n         = 1'b1;
            bus.opcode    = op;
            bus.funct3    = f3;
            bus.funct7_5  = f7;
            bus.zero      = zf;
            bus.mem_ready = seq[i].rdy;
            #2;
            check({name, ":state"}, 32'(bus.state_o), 32'(seq[i].st));
            check({name, ":outs"}, 32'(got_outs()),
                  32'(exp_outs(seq[i].st, seq[i].rdy, zf, f3, f7)));
            check({name, ":flags"}, 32'({bus.illegal_instr, bus.mem_error}),
                  32'({seq[i].ill, seq[i].merr}));
        end
        if (cause != 0) do_reset({name, ":clr"});
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         kind;
        logic [2:0] r_ok [4];

        bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        r_ok[0] = 3'b000; r_ok[1] = 3'b111; r_ok[2] = 3'b110; r_ok[3] = 3'b010;

        do_reset("init");

        play("add",      OP_R,   3'b000, 1'b0, 1'b0, 0, 0, 0, -1);
        play("sub",      OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 0, -1);
        play("and",      OP_R,   3'b111, 1'b0, 1'b0, 0, 0, 0, -1);
        play("or",       OP_R,   3'b110, 1'b0, 1'b0, 0, 0, 0, -1);
        play("slt",      OP_R,   3'b010, 1'b0, 1'b0, 0, 0, 0, -1);
        play("lw_w3",    OP_LW,  3'b010, 1'b0, 1'b0, 0, 3, 0, -1);
        play("sw",       OP_SW,  3'b010, 1'b0, 1'b0, 0, 0, 0, -1);
        play("sw_w2",    OP_SW,  3'b010, 1'b0, 1'b0, 0, 2, 0, -1);
        play("beq_z1",   OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 0, -1);
        play("beq_z0",   OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 0, -1);
        play("ill_op",   7'h7F,  3'b000, 1'b0, 1'b0, 0, 0, 21, -1);
        play("ill_sltf7",OP_R,   3'b010, 1'b1, 1'b0, 0, 0, 3, -1);
        play("fetch_to", OP_R,   3'b000, 1'b0, 1'b0, T, 0, 3, -1);
        play("fetch_w3", OP_R,   3'b000, 1'b0, 1'b0, T - 1, 0, 0, -1);
        play("lw_to",    OP_LW,  3'b010, 1'b0, 1'b0, 0, T, 2, -1);
        play("sw_to",    OP_SW,  3'b010, 1'b0, 1'b0, 0, T + 1, 2, -1);
        play("abort_ex", OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 0, 2);
        play("after_ab", OP_SW,  3'b010, 1'b0, 1'b0, 1, 1, 0, -1);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            f3   = 3'($urandom);
            f7   = 1'($urandom);
            case (kind)
                0: begin op = OP_R; f3 = r_ok[$urandom_range(0, 3)];
                         if (f3 != 3'b000) f7 = 1'b0; end
                1: begin op = OP_R;
                         while (f3 == 3'b000 ||
                                (!f7 && (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010))) begin
                             f3 = 3'($urandom); f7 = 1'($urandom);
                         end
                   end
                2: begin op = OP_LW;  if ($urandom_range(0, 7) != 0) f3 = 3'b010; end
                3: begin op = OP_SW;  if ($urandom_range(0, 7) != 0) f3 = 3'b010; end
                4: begin op = OP_BEQ; if ($urandom_range(0, 7) != 0) f3 = 3'b000; end
                default: begin
                    op = 7'($urandom);
                    while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ)
                        op = 7'($urandom);
                end
            endcase
            play($sformatf("rnd%0d", n), op, f3, f7, 1'($urandom),
                 ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, T + 1),
                 ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, T + 1),
                 $urandom_range(1, 4),
                 ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
